// File: rtl/iob_split_pipe.sv
// Pipelined native-bus splitter: one master to N_SLAVES slaves, up to MAX_OUT
// requests in flight, in-order responses, unmapped selects answered locally with m_err.

module iob_split_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             req,
  input  logic [SEL_W-1:0] sel,
  output logic             valid
);
  localparam logic [SEL_W-1:0] ID = IDX[SEL_W-1:0];
  assign valid = req && (sel == ID);
endmodule

module iob_split_pipe #(
  parameter int N_SLAVES = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int P_SLAVES = 31,
  parameter int MAX_OUT  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_ack,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_rvalid,
  output logic                         m_err,
  output logic [N_SLAVES-1:0]          s_valid,
  output logic [N_SLAVES*ADDR_W-1:0]   s_addr,
  output logic [N_SLAVES*DATA_W-1:0]   s_wdata,
  output logic [N_SLAVES*DATA_W/8-1:0] s_wstrb,
  input  logic [N_SLAVES-1:0]          s_ack,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]          s_rvalid
);
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int NP    = 1 << SEL_W;
  localparam int PW    = $clog2(MAX_OUT);

  typedef struct packed {
    logic             err;
    logic [SEL_W-1:0] idx;
  } ent_t;

  ent_t                  fifo [MAX_OUT];
  ent_t                  head;
  logic [PW-1:0]         wptr, rptr;
  logic [PW:0]           count, err_cnt;
  logic [SEL_W-1:0]      last_sel, sel;
  logic                  unmapped, full, issue_ok, push, pop;
  logic [NP-1:0]         ack_pad, rv_pad;
  logic [NP-1:0][DATA_W-1:0] rd_pad;

  // Pad per-slave vectors to the full select range so unmapped indices read as 0.
  assign ack_pad = NP'(s_ack);
  assign rv_pad  = NP'(s_rvalid);
  assign rd_pad  = (NP*DATA_W)'(s_rdata);

  assign sel      = m_addr[P_SLAVES -: SEL_W];
  assign unmapped = {1'b0, sel} >= (SEL_W+1)'(N_SLAVES);
  assign full     = count == (PW+1)'(MAX_OUT);
  // A single mapped target at a time keeps responses in order without reorder buffers.
  assign issue_ok = !full && (count == '0 || sel == last_sel || err_cnt == count);
  assign m_ack    = issue_ok && (unmapped || ack_pad[sel]);
  assign push     = m_valid && m_ack;

  assign head = fifo[rptr];
  assign pop  = (count != '0) && (head.err || rv_pad[head.idx]);

  assign s_addr  = {N_SLAVES{m_addr}};
  assign s_wdata = {N_SLAVES{m_wdata}};
  assign s_wstrb = {N_SLAVES{m_wstrb}};

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_lane
    iob_split_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .req   (m_valid && issue_ok && !unmapped),
      .sel   (sel),
      .valid (s_valid[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      err_cnt  <= '0;
      last_sel <= '0;
      m_rvalid <= 1'b0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= '{err: unmapped, idx: sel};
        wptr       <= wptr + 1'b1;
        last_sel   <= sel;
      end
      if (pop) begin
        rptr    <= rptr + 1'b1;
        m_rdata <= head.err ? '0 : rd_pad[head.idx];
      end
      m_rvalid <= pop;
      m_err    <= pop && head.err;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({push && unmapped, pop && head.err})
        2'b10:   err_cnt <= err_cnt + 1'b1;
        2'b01:   err_cnt <= err_cnt - 1'b1;
        default: err_cnt <= err_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_iob_split_pipe.sv
// Bench for iob_split_pipe: directed scenarios with literal checks, then random
// traffic against a queue-based model of the outstanding requests.

module tb_iob_split_pipe;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW/8;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [SW-1:0] m_wstrb = '0;
  logic          m_ack, m_rvalid, m_err;
  logic [DW-1:0] m_rdata;
  logic [N-1:0]    s_valid;
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_wdata;
  logic [N*SW-1:0] s_wstrb;
  logic [N-1:0]    s_ack    = '0;
  logic [N*DW-1:0] s_rdata  = '0;
  logic [N-1:0]    s_rvalid = '0;

  iob_split_pipe #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .P_SLAVES(31), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ack(m_ack), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_err(m_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ack(s_ack), .s_rdata(s_rdata), .s_rvalid(s_rvalid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of outstanding requests, each either an error or a slave index.
  typedef struct { bit err; int idx; } ment_t;
  ment_t         mq[$];
  int            m_last = 0;
  bit            exp_rv = 0, exp_er = 0, armed = 0;
  logic [DW-1:0] exp_rd = '0;

  // Slave models: pending response data per slave.
  logic [DW-1:0] sq[N][$];
  bit            auto_sl = 0;
  logic [N-1:0]  acc_rec = '0, rsp_rec = '0;
  bit            mack_rec = 0, rst_rec = 0;

  task automatic compare_cycle();
    int sel; bit unm, ok, allerr, push, pop, eack;
    logic [N-1:0] esv;
    sel = int'(m_addr[31:30]);
    unm = sel >= N;
    allerr = 1;
    foreach (mq[k]) if (!mq[k].err) allerr = 0;
    ok   = mq.size() < MO && (mq.size() == 0 || sel == m_last || allerr);
    eack = ok && (unm ? 1'b1 : s_ack[sel]);
    if (armed) begin
      chk("m_rvalid", 64'(m_rvalid), 64'(exp_rv));
      if (exp_rv) begin
        chk("m_err", 64'(m_err), 64'(exp_er));
        chk("m_rdata", 64'(m_rdata), 64'(exp_rd));
      end
      if (rst) begin
        esv = (m_valid && ok && !unm) ? N'(1) << sel : '0;
        chk("s_valid", 64'(s_valid), 64'(esv));
        chk("m_ack", 64'(m_ack), 64'(eack));
        chk("s_addr", 64'(s_addr[(N-1)*AW +: AW]), 64'(m_addr));
        chk("s_wstrb", 64'(s_wstrb[SW-1:0]), 64'(m_wstrb));
      end
    end
    acc_rec = s_valid & s_ack; rsp_rec = s_rvalid; mack_rec = m_ack; rst_rec = rst;
    if (!rst) begin
      mq.delete(); m_last = 0; exp_rv = 0; exp_er = 0; exp_rd = '0; armed = 1;
    end else if (armed) begin
      push = m_valid && eack;
      pop = 0; exp_er = 0;
      if (mq.size() > 0) begin
        if (mq[0].err) begin pop = 1; exp_er = 1; exp_rd = '0; end
        else if (s_rvalid[mq[0].idx]) begin pop = 1; exp_rd = s_rdata[mq[0].idx*DW +: DW]; end
      end
      exp_rv = pop;
      if (pop) void'(mq.pop_front());
      if (push) begin mq.push_back('{unm, sel}); m_last = sel; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (!rst_rec) sq[i].delete();
      else begin
        if (rsp_rec[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        if (acc_rec[i]) sq[i].push_back($urandom);
      end
    end
    if (auto_sl) begin
      for (int i = 0; i < N; i++) begin
        s_ack[i] = ($urandom % 4) != 0;
        if (sq[i].size() > 0 && $urandom % 2 == 1) begin
          s_rvalid[i] = 1'b1; s_rdata[i*DW +: DW] = sq[i][0];
        end else begin
          s_rvalid[i] = 1'b0; s_rdata[i*DW +: DW] = $urandom;
        end
      end
    end
  endtask

  int psel = 0;

  initial begin
    // Reset with random inputs
    rst = 1'b0;
    repeat (3) begin
      m_valid = 1'($urandom); m_addr = $urandom; s_ack = N'($urandom); s_rvalid = N'($urandom);
      tick();
    end
    chk("rst_rvalid", 64'(m_rvalid), 64'd0);
    chk("rst_err", 64'(m_err), 64'd0);
    chk("rst_rdata", 64'(m_rdata), 64'd0);
    rst = 1'b1; m_valid = 1'b0; s_ack = '0; s_rvalid = '0; #1;
    chk("idle_s_valid", 64'(s_valid), 64'd0);

    // Single read to slave 1
    m_valid = 1'b1; m_addr = 32'h4000_0010; m_wstrb = '0; s_ack = 3'b010; #1;
    chk("rd_s_valid", 64'(s_valid), 64'b010);
    chk("rd_ack", 64'(m_ack), 64'd1);
    tick(); m_valid = 1'b0; s_ack = '0;
    tick(); s_rvalid = 3'b010; s_rdata[DW +: DW] = 32'hDEAD_BEEF;
    tick(); s_rvalid = '0;
    chk("rd_rvalid", 64'(m_rvalid), 64'd1);
    chk("rd_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    chk("rd_err", 64'(m_err), 64'd0);

    // Unmapped select, then a normal request to slave 0, then a target switch
    m_valid = 1'b1; m_addr = 32'hC000_0000; #1;
    chk("um_ack", 64'(m_ack), 64'd1);
    chk("um_s_valid", 64'(s_valid), 64'd0);
    tick(); m_valid = 1'b0;
    chk("um_rvalid_early", 64'(m_rvalid), 64'd0);
    tick();
    chk("um_rvalid", 64'(m_rvalid), 64'd1);
    chk("um_err", 64'(m_err), 64'd1);
    chk("um_rdata", 64'(m_rdata), 64'd0);
    m_valid = 1'b1; m_addr = 32'h0000_0000; s_ack = 3'b001; #1;
    chk("um_next_ack", 64'(m_ack), 64'd1);
    tick();
    m_addr = 32'h8000_0004; s_ack = 3'b111; #1;
    chk("sw_s_valid", 64'(s_valid), 64'd0);
    chk("sw_ack", 64'(m_ack), 64'd0);
    tick(); s_rvalid = 3'b001; s_rdata[DW-1:0] = 32'h0000_1234; #1;
    chk("sw_ack_pop", 64'(m_ack), 64'd0);
    tick(); s_rvalid = '0; #1;
    chk("sw_ack_after", 64'(m_ack), 64'd1);
    chk("sw_s_valid_after", 64'(s_valid), 64'b100);
    chk("sw_rdata", 64'(m_rdata), 64'h1234);
    tick(); m_valid = 1'b0; s_ack = '0; s_rvalid = 3'b100;
    tick(); s_rvalid = '0;
    tick();

    // Fill the FIFO on slave 0
    s_ack = 3'b001;
    for (int k = 0; k < 5; k++) begin
      m_valid = 1'b1; m_addr = 32'(k * 4); #1;
      chk("fill_ack", 64'(m_ack), 64'(k < 4));
      if (k < 4) tick();
    end
    tick(); #1;
    chk("fill_stall", 64'(m_ack), 64'd0);
    s_rvalid = 3'b001; s_rdata[DW-1:0] = 32'h100; #1;
    chk("fill_full_pop_ack", 64'(m_ack), 64'd0);
    tick(); s_rvalid = '0; #1;
    chk("fill_ack5", 64'(m_ack), 64'd1);
    chk("fill_rdata0", 64'(m_rdata), 64'h100);
    tick(); m_valid = 1'b0; s_ack = '0;
    for (int k = 1; k <= 4; k++) begin
      s_rvalid = 3'b001; s_rdata[DW-1:0] = 32'(32'h100 + k);
      tick();
      chk("fill_rvalid", 64'(m_rvalid), 64'd1);
      chk("fill_rdata", 64'(m_rdata), 64'(32'h100 + k));
    end
    s_rvalid = '0; tick();

    // Reset mid-operation
    s_ack = 3'b010; m_valid = 1'b1; m_addr = 32'h4000_0000; tick();
    m_addr = 32'h4000_0004; tick();
    m_valid = 1'b0; s_ack = '0; rst = 1'b0; tick();
    rst = 1'b1; s_rvalid = 3'b010; tick();
    chk("mr_rvalid0", 64'(m_rvalid), 64'd0);
    tick(); s_rvalid = '0;
    chk("mr_rvalid1", 64'(m_rvalid), 64'd0);
    m_valid = 1'b1; m_addr = 32'h8000_0000; s_ack = 3'b100; #1;
    chk("mr_empty_ack", 64'(m_ack), 64'd1);
    tick(); m_valid = 1'b0; s_ack = '0; s_rvalid = 3'b100;
    tick(); s_rvalid = '0;
    tick();

    // Random traffic
    auto_sl = 1;
    for (int c = 0; c < 4000; c++) begin
      if (!m_valid || mack_rec) begin
        if ($urandom % 3 != 0) begin
          if ($urandom % 10 >= 7) psel = int'($urandom % 4);
          m_valid = 1'b1;
          m_addr  = {2'(psel), 30'($urandom)};
          m_wdata = $urandom;
          m_wstrb = ($urandom % 2 == 1) ? SW'($urandom) : '0;
        end else m_valid = 1'b0;
      end
      rst = ($urandom % 300 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    m_valid = 1'b0; rst = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
